serial_frame_rx: RTL and testbench
==================================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the number of payload bits per frame.
REQ-002 Parameter PARITY_EN, default 1, SHALL enable the even-parity bit; when 0, the frame SHALL omit the parity bit.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 serial_in  input  1  SHALL carry the serial line from the upstream shift-register stage, one bit per clk.
REQ-006 data_out  output  DATA_W  SHALL hold the received payload.
REQ-007 data_valid  output  1  SHALL indicate that data_out holds an unconsumed frame.
REQ-008 data_ready  input  1  SHALL be driven by the consumer to accept data_out.
REQ-009 parity_err  output  1  SHALL flag a parity mismatch on the frame held in data_out; it SHALL be valid only when data_valid=1.
REQ-010 frame_err  output  1  SHALL be a one-cycle pulse when the stop bit is not 0.
REQ-011 overrun  output  1  SHALL be a one-cycle pulse when a completed frame is dropped.

Function
REQ-012 Line idle level SHALL be 0, matching the upstream stage's reset value; start bit = 1, stop bit = 0.
REQ-013 Frame order SHALL be: start, DATA_W payload bits LSB first, parity (if PARITY_EN), stop.
REQ-014 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-015 IDLE->DATA SHALL occur on the first sampled serial_in=1; the bit counter SHALL be cleared.
REQ-016 DATA SHALL shift in one bit per cycle and leave after exactly DATA_W bits, going to PARITY (PARITY_EN=1) or STOP.
REQ-017 PARITY SHALL sample one bit and compute parity_err = XOR(payload, parity bit), so even parity holds when the XOR is 0; the FSM SHALL then go to STOP.
REQ-018 STOP with serial_in=0 SHALL complete the frame and return to IDLE.
REQ-019 STOP with serial_in=1 SHALL pulse frame_err, discard the frame, and return to IDLE; that 1 SHALL NOT be treated as a new start bit.
REQ-020 On completion, data_out, parity_err, and data_valid=1 SHALL appear the cycle after the stop bit is sampled; latency SHALL be DATA_W+2+PARITY_EN cycles from the start-bit sample.
REQ-021 A transfer SHALL occur when data_valid=1 and data_ready=1 on the same edge; data_valid SHALL then clear unless a new frame completes on that same edge.
REQ-022 If a frame completes on the same edge as a transfer, the new frame SHALL load and data_valid SHALL stay 1.
REQ-023 If a frame completes while data_valid=1 and data_ready=0, the new frame SHALL be dropped, overrun SHALL pulse, and the held data SHALL be unchanged.
REQ-024 data_out and parity_err SHALL stay stable while data_valid=1 and no transfer has occurred.
REQ-025 Reception SHALL continue in all states regardless of data_valid; back-to-back frames (start bit immediately after stop) SHALL be accepted.

Reset
REQ-026 Rst_n=0 SHALL immediately force IDLE, bit counter 0, shift register 0, data_out 0, data_valid 0, parity_err 0, frame_err 0, overrun 0.
REQ-027 Reset asserted mid-frame SHALL abandon the partial frame with no error pulse.
REQ-028 After Rst_n deasserts, the first serial_in=1 SHALL be taken as a start bit.

Structure
REQ-029 A shared package SHALL hold the FSM state typedef, START_BIT=1, STOP_BIT=0, and IDLE_LEVEL=0.
REQ-030 The output holding register with its valid/ready logic SHALL be the sub-module rx_hold_reg; the FSM and shifter SHALL live in serial_frame_rx.

Verification
REQ-031 Send frame 0xA5 with parity 0 and stop 0 (ready=1) -> data_out=0xA5, data_valid=1 for one cycle, parity_err=0, 11 cycles after the start bit.
REQ-032 Send 0x01 with parity bit 0 -> data_valid=1 with parity_err=1.
REQ-033 Send 0x3C with stop bit 1 -> frame_err pulses, data_valid stays 0, FSM in IDLE next cycle.
REQ-034 Hold ready=0, send 0x11 then 0x22 back-to-back -> data_out=0x11 retained, overrun pulses once; raising ready -> one transfer of 0x11.
REQ-035 Assert Rst_n=0 after 4 payload bits, release, send 0x5A -> no error pulses, data_out=0x5A.
REQ-036 Set ready=1 on the edge where the next frame completes -> seamless reload, data_valid remains 1, no overrun.

Source files
------------

// File: rtl/serial_frame_rx_pkg.sv
// Shared line-level constants and FSM state encoding for the serial frame receiver.
package serial_frame_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    localparam logic START_BIT  = 1'b1;
    localparam logic STOP_BIT   = 1'b0;
    localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/serial_frame_rx_hold_reg.sv
// Output holding register: one frame of buffering with valid/ready handshake and overrun detect.
module rx_hold_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_perr,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_perr,
    output logic              o_overrun
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_perr;
    logic              r_overrun;
    logic              w_xfer;
    logic              w_accept;

    // A frame is accepted into an empty register or into one being drained this edge.
    assign w_xfer   = r_valid & i_ready;
    assign w_accept = i_load & (~r_valid | w_xfer);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_load & r_valid & ~i_ready;
            if (w_accept) begin
                r_data  <= i_data;
                r_perr  <= i_perr;
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_perr    = r_perr;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, LSB-first payload, optional even parity, stop bit.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_err;
    logic              r_done;
    logic              r_frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= {DATA_W{IDLE_LEVEL}};
            r_par_err   <= 1'b0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (serial_in == START_BIT) begin
                        r_state   <= ST_DATA;
                        r_cnt     <= '0;
                        r_par_err <= 1'b0;
                    end
                end
                ST_DATA: begin
                    r_shift <= {serial_in, r_shift[DATA_W-1:1]};
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        r_cnt   <= '0;
                        r_state <= PARITY_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    // Even parity: payload XOR parity bit must be zero.
                    r_par_err <= (^r_shift) ^ serial_in;
                    r_state   <= ST_STOP;
                end
                ST_STOP: begin
                    // A bad stop bit is consumed here, never reused as a start bit.
                    if (serial_in == STOP_BIT) begin
                        r_done <= 1'b1;
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    rx_hold_reg #(
        .DATA_W(DATA_W)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (r_done),
        .i_data    (r_shift),
        .i_perr    (r_par_err),
        .i_ready   (data_ready),
        .o_data    (data_out),
        .o_valid   (data_valid),
        .o_perr    (parity_err),
        .o_overrun (overrun)
    );

    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: one task per scenario with inline hand-computed checks.
module tb_serial_frame_rx;

    logic       clk;
    logic       rst_n;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int n_chk  = 0;
    int n_pass = 0;

    serial_frame_rx #(
        .DATA_W   (8),
        .PARITY_EN(1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .serial_in (serial_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        step();
    endtask

    // Drives start, 8 payload bits LSB first, parity, stop; returns 1 time unit after the stop-bit edge.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bit(1'b1);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        serial_in  = 1'b0;
        data_ready = 1'b0;
        #1;
        n_chk++; if (data_out !== 8'h00) $display("FAIL reset_data: got %0h expected 00", data_out); else n_pass++;
        n_chk++; if (data_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", data_valid); else n_pass++;
        n_chk++; if (parity_err !== 1'b0) $display("FAIL reset_perr: got %0b expected 0", parity_err); else n_pass++;
        n_chk++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %0b expected 0", frame_err); else n_pass++;
        n_chk++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %0b expected 0", overrun); else n_pass++;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        data_ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0);
        n_chk++; if (data_valid !== 1'b0) $display("FAIL basic_early_valid: got %0b expected 0", data_valid); else n_pass++;
        send_bit(1'b0);
        n_chk++; if (data_valid !== 1'b1) $display("FAIL basic_valid: got %0b expected 1", data_valid); else n_pass++;
        n_chk++; if (data_out !== 8'hA5) $display("FAIL basic_data: got %0h expected a5", data_out); else n_pass++;
        n_chk++; if (parity_err !== 1'b0) $display("FAIL basic_perr: got %0b expected 0", parity_err); else n_pass++;
        send_bit(1'b0);
        n_chk++; if (data_valid !== 1'b0) $display("FAIL basic_valid_one_cycle: got %0b expected 0", data_valid); else n_pass++;
    endtask

    task automatic test_parity_err();
        data_ready = 1'b1;
        send_frame(8'h01, 1'b0, 1'b0);
        send_bit(1'b0);
        n_chk++; if (data_valid !== 1'b1) $display("FAIL perr_valid: got %0b expected 1", data_valid); else n_pass++;
        n_chk++; if (data_out !== 8'h01) $display("FAIL perr_data: got %0h expected 01", data_out); else n_pass++;
        n_chk++; if (parity_err !== 1'b1) $display("FAIL perr_flag: got %0b expected 1", parity_err); else n_pass++;
        send_bit(1'b0);
    endtask

    task automatic test_frame_err();
        data_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1);
        n_chk++; if (frame_err !== 1'b1) $display("FAIL ferr_pulse: got %0b expected 1", frame_err); else n_pass++;
        n_chk++; if (data_valid !== 1'b0) $display("FAIL ferr_valid0: got %0b expected 0", data_valid); else n_pass++;
        send_bit(1'b0);
        n_chk++; if (frame_err !== 1'b0) $display("FAIL ferr_one_cycle: got %0b expected 0", frame_err); else n_pass++;
        n_chk++; if (data_valid !== 1'b0) $display("FAIL ferr_valid1: got %0b expected 0", data_valid); else n_pass++;
        send_bit(1'b0);
        n_chk++; if (data_valid !== 1'b0) $display("FAIL ferr_discard: got %0b expected 0", data_valid); else n_pass++;
        // Bad stop bit must have left the FSM idle: a following frame decodes cleanly.
        send_frame(8'h96, 1'b0, 1'b0);
        send_bit(1'b0);
        n_chk++; if (data_out !== 8'h96 || data_valid !== 1'b1) $display("FAIL ferr_recover: got %0h/%0b expected 96/1", data_out, data_valid); else n_pass++;
        send_bit(1'b0);
    endtask

    task automatic test_overrun();
        data_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        n_chk++; if (data_valid !== 1'b1 || data_out !== 8'h11) $display("FAIL ovr_hold: got %0h/%0b expected 11/1", data_out, data_valid); else n_pass++;
        n_chk++; if (overrun !== 1'b0) $display("FAIL ovr_early: got %0b expected 0", overrun); else n_pass++;
        send_bit(1'b0);
        n_chk++; if (overrun !== 1'b1) $display("FAIL ovr_pulse: got %0b expected 1", overrun); else n_pass++;
        n_chk++; if (data_out !== 8'h11) $display("FAIL ovr_retain: got %0h expected 11", data_out); else n_pass++;
        send_bit(1'b0);
        n_chk++; if (overrun !== 1'b0) $display("FAIL ovr_single: got %0b expected 0", overrun); else n_pass++;
        n_chk++; if (data_valid !== 1'b1 || data_out !== 8'h11) $display("FAIL ovr_stable: got %0h/%0b expected 11/1", data_out, data_valid); else n_pass++;
        data_ready = 1'b1;
        send_bit(1'b0);
        n_chk++; if (data_valid !== 1'b0) $display("FAIL ovr_transfer: got %0b expected 0", data_valid); else n_pass++;
        send_bit(1'b0);
        n_chk++; if (data_valid !== 1'b0) $display("FAIL ovr_one_xfer: got %0b expected 0", data_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        data_ready = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rst_n = 1'b0;
        #1;
        n_chk++; if (data_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) $display("FAIL rstmid_flags: got v%0b f%0b o%0b expected 000", data_valid, frame_err, overrun); else n_pass++;
        n_chk++; if (data_out !== 8'h00) $display("FAIL rstmid_data: got %0h expected 00", data_out); else n_pass++;
        #1;
        rst_n     = 1'b1;
        serial_in = 1'b0;
        step();
        step();
        send_frame(8'h5A, 1'b0, 1'b0);
        n_chk++; if (frame_err !== 1'b0) $display("FAIL rstmid_ferr: got %0b expected 0", frame_err); else n_pass++;
        send_bit(1'b0);
        n_chk++; if (data_out !== 8'h5A || data_valid !== 1'b1) $display("FAIL rstmid_frame: got %0h/%0b expected 5a/1", data_out, data_valid); else n_pass++;
        n_chk++; if (parity_err !== 1'b0 || overrun !== 1'b0) $display("FAIL rstmid_errs: got p%0b o%0b expected 00", parity_err, overrun); else n_pass++;
        send_bit(1'b0);
    endtask

    task automatic test_back_to_back();
        data_ready = 1'b0;
        send_frame(8'h33, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0);
        n_chk++; if (data_out !== 8'h33 || data_valid !== 1'b1) $display("FAIL b2b_first: got %0h/%0b expected 33/1", data_out, data_valid); else n_pass++;
        data_ready = 1'b1;
        send_bit(1'b0);
        n_chk++; if (data_valid !== 1'b1) $display("FAIL b2b_valid: got %0b expected 1", data_valid); else n_pass++;
        n_chk++; if (data_out !== 8'hC3) $display("FAIL b2b_reload: got %0h expected c3", data_out); else n_pass++;
        n_chk++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %0b expected 0", overrun); else n_pass++;
        send_bit(1'b0);
        n_chk++; if (data_valid !== 1'b0) $display("FAIL b2b_drain: got %0b expected 0", data_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_err();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
